fifo_rd_sched: RTL
==================

# fifo_rd_sched

Packet read scheduler directly downstream of the FIFO selection stage. Consumes the 8-bit selection code (bit 7 = valid, bits [6:0] = port index, 8'd0 = nothing selected), locks onto the chosen port FIFO and pops exactly one packet (up to EOP) into a 2-entry output buffer with ready/valid backpressure. After a hold-off it re-arbitrates, so one packet is moved per grant.

## Interface
- PORT_NUM, 4, number of port FIFOs (1..127)
- DATA_W, 32, FIFO/output word width
- MAX_WORDS, 1024, packet length limit in words (2..65535); reaching it without EOP aborts the packet
- HOLDOFF_CYC, 2, idle cycles after a packet before a new selection code is sampled (1..15)

Ports:
- glb_clk  in  1  single clock; all logic on rising edge
- glb_areset  in  1  asynchronous, active-high reset
- fifo_sel_code  in  8  selection code from the selection stage
- fifo_empty  in  PORT_NUM  per-port empty flag
- fifo_rd_data  in  PORT_NUM*DATA_W  first-word-fall-through head word; port i at [i*DATA_W +: DATA_W]
- fifo_rd_eop  in  PORT_NUM  EOP flag of head word, per port
- fifo_rd_en  out  PORT_NUM  one-hot pop strobe (combinational)
- out_data  out  DATA_W  output buffer head word
- out_eop  out  1  head word is last of packet
- out_valid  out  1  output buffer non-empty
- out_ready  in  1  downstream accepts head word
- busy  out  1  state != IDLE
- cur_port  out  7  latched port index
- pkt_done  out  1  1-cycle pulse, packet ended normally
- pkt_err  out  1  1-cycle pulse, packet aborted (MAX_WORDS) or invalid index
- pkt_len  out  16  word count of last finished packet

## Operation
- States: IDLE, RD, HOLD.
- IDLE: if fifo_sel_code[7]=1 and fifo_sel_code[6:0] < PORT_NUM -> latch cur_port, clear word counter, go RD. If bit7=1 and index >= PORT_NUM -> pkt_err pulse, stay IDLE. Codes with bit7=0 ignored.
- RD: pop = !fifo_empty[cur_port] && (occ < 2 || (out_valid && out_ready)); fifo_rd_en[cur_port] = pop, all other bits 0. A popped word is written into the output buffer with its EOP flag; word counter increments.
- Popped word with EOP=1 -> go HOLD; next cycle pkt_done=1, pkt_len = count including EOP word.
- Popped word with EOP=0 where count+1 == MAX_WORDS -> word written with out_eop forced to 1, go HOLD; next cycle pkt_err=1, pkt_len=MAX_WORDS. Remaining words of that packet stay in the FIFO.
- Empty FIFO in RD: no pop, stay in RD indefinitely (no timeout).
- HOLD: count HOLDOFF_CYC cycles, then IDLE. fifo_sel_code ignored in RD and HOLD.
- Output buffer: 2-entry FIFO, occ in 0..2; simultaneous push and pop at occ=2 permitted; push never occurs at occ=2 without pop. Order preserved across packets; buffered words continue to drain while in HOLD/IDLE.
- Reset (any time, including mid-packet): state IDLE, occ=0, out_valid=0, out_data=0, out_eop=0, fifo_rd_en=0, busy=0, cur_port=0, pkt_done=0, pkt_err=0, pkt_len=0, counters 0. Partially read packet is not recovered.

## Timing
- Code sampled in IDLE at edge N -> busy=1 and first fifo_rd_en possible in cycle N+1 -> first out_valid in cycle N+2.
- Full throughput: one word/cycle while FIFO non-empty and out_ready=1.
- fifo_rd_en is combinational from registered state, fifo_empty, occ, out_ready; no combinational path from fifo_sel_code.
- EOP pop in cycle K -> pkt_done/pkt_err and pkt_len valid in K+1; IDLE in K+1+HOLDOFF_CYC; earliest next grant sampled at that edge.
- out_ready=0 with occ=2 -> fifo_rd_en=0 same cycle.

## Test plan
- Port 2 holds 3-word packet (A,B,C eop), code 8'h82, out_ready=1 -> fifo_rd_en=4'b0100 for 3 consecutive cycles, out A,B,C with out_eop on C, pkt_done=1, pkt_len=3, busy drops after HOLDOFF_CYC.
- Same packet, out_ready toggling 1,0,0,1,1 -> no word lost or duplicated, occ never >2, fifo_rd_en=0 whenever occ=2 and out_ready=0.
- MAX_WORDS=4, port 0 has 6 words without EOP -> 4 words out, 4th with out_eop=1, pkt_err=1, pkt_len=4, 2 words remain in FIFO.
- Code 8'h85 with PORT_NUM=4 -> pkt_err pulse, busy stays 0, no fifo_rd_en.
- Code changes from 8'h81 to 8'h83 mid-packet -> ignored; port 1 packet completes, port 3 served only after HOLD.
- glb_areset asserted mid-packet with occ=2 -> all outputs zero immediately (async); after release, code 8'h80 starts a fresh packet with pkt_len counting from 0.

Source files
------------

// File: rtl/fifo_rd_sched_if.sv
// Handshake bundle between the FIFO selection stage, the port FIFOs,
// the packet read scheduler and the downstream consumer.
interface fifo_rd_sched_if #(
    parameter int PORT_NUM = 4,
    parameter int DATA_W   = 32
);
    logic [7:0]                 fifo_sel_code;
    logic [PORT_NUM-1:0]        fifo_empty;
    logic [PORT_NUM*DATA_W-1:0] fifo_rd_data;
    logic [PORT_NUM-1:0]        fifo_rd_eop;
    logic [PORT_NUM-1:0]        fifo_rd_en;
    logic [DATA_W-1:0]          out_data;
    logic                       out_eop;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;
    logic [6:0]                 cur_port;
    logic                       pkt_done;
    logic                       pkt_err;
    logic [15:0]                pkt_len;

    modport master (
        input  fifo_sel_code, fifo_empty, fifo_rd_data, fifo_rd_eop,
        input  out_ready,
        output fifo_rd_en, out_data, out_eop, out_valid,
        output busy, cur_port, pkt_done, pkt_err, pkt_len
    );

    modport slave (
        output fifo_sel_code, fifo_empty, fifo_rd_data, fifo_rd_eop,
        output out_ready,
        input  fifo_rd_en, out_data, out_eop, out_valid,
        input  busy, cur_port, pkt_done, pkt_err, pkt_len
    );
endinterface

// File: rtl/fifo_rd_sched.sv
// Packet read scheduler: locks onto the selected port FIFO and moves
// exactly one packet per grant into a 2-entry output buffer.
module fifo_rd_sched #(
    parameter int PORT_NUM    = 4,
    parameter int DATA_W      = 32,
    parameter int MAX_WORDS   = 1024,
    parameter int HOLDOFF_CYC = 2
) (
    input  logic            glb_clk,
    input  logic            glb_areset,
    fifo_rd_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, HOLD} state_t;

    state_t              state;
    logic [6:0]          cur_port;
    logic [15:0]         word_cnt;
    logic [3:0]          hold_cnt;
    logic [DATA_W-1:0]   buf_data [2];
    logic                buf_eop  [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          occ;

    logic [PORT_NUM-1:0] sel;
    logic [DATA_W-1:0]   head_data;
    logic                head_eop;
    logic                head_empty;
    logic                drain;
    logic                pop;
    logic [15:0]         wc_next;
    logic                at_max;
    logic                last;

    always_comb begin
        sel       = '0;
        head_data = '0;
        head_eop  = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            sel[i] = (cur_port == 7'(i));
            if (sel[i]) begin
                head_data = head_data | bus.fifo_rd_data[i*DATA_W +: DATA_W];
                head_eop  = head_eop | bus.fifo_rd_eop[i];
            end
        end
        head_empty = ~|(sel & ~bus.fifo_empty);
    end

    assign drain   = bus.out_valid && bus.out_ready;
    assign pop     = (state == RD) && !head_empty && (occ != 2'd2 || drain);
    assign wc_next = word_cnt + 16'd1;
    assign at_max  = (wc_next == 16'(MAX_WORDS));
    assign last    = pop && (head_eop || at_max);

    assign bus.fifo_rd_en = pop ? sel : '0;
    assign bus.out_data   = buf_data[rd_ptr];
    assign bus.out_eop    = buf_eop[rd_ptr];
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.busy       = (state != IDLE);
    assign bus.cur_port   = cur_port;

    // Truncated packets get a forced EOP so downstream framing stays intact.
    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_eop[0]  <= 1'b0;
            buf_eop[1]  <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (pop) begin
                buf_data[wr_ptr] <= head_data;
                buf_eop[wr_ptr]  <= head_eop | at_max;
                wr_ptr           <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, pop} - {1'b0, drain};
        end
    end

    always_ff @(posedge glb_clk or posedge glb_areset) begin
        if (glb_areset) begin
            state        <= IDLE;
            cur_port     <= '0;
            word_cnt     <= '0;
            hold_cnt     <= '0;
            bus.pkt_done <= 1'b0;
            bus.pkt_err  <= 1'b0;
            bus.pkt_len  <= '0;
        end else begin
            bus.pkt_done <= 1'b0;
            bus.pkt_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.fifo_sel_code[7]) begin
                        if (bus.fifo_sel_code[6:0] < 7'(PORT_NUM)) begin
                            cur_port <= bus.fifo_sel_code[6:0];
                            word_cnt <= '0;
                            state    <= RD;
                        end else begin
                            bus.pkt_err <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (pop) begin
                        word_cnt <= wc_next;
                        if (last) begin
                            state        <= HOLD;
                            hold_cnt     <= '0;
                            bus.pkt_len  <= wc_next;
                            bus.pkt_done <= head_eop;
                            bus.pkt_err  <= !head_eop;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == 4'(HOLDOFF_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
